// File: rtl/delta_pkg.sv
// delta_pkg: definitions shared by the delta decoder and the future delta encoder.
//   ST_WAIT_KEY / ST_RUN : decoder state encodings
//   FLAG_KEY / FLAG_DELTA: values of the key/delta flag on the stream
package delta_pkg;

    localparam logic ST_WAIT_KEY = 1'b0;
    localparam logic ST_RUN      = 1'b1;

    localparam logic FLAG_KEY    = 1'b1;
    localparam logic FLAG_DELTA  = 1'b0;

    typedef enum logic {
        S_WAIT_KEY = ST_WAIT_KEY,
        S_RUN      = ST_RUN
    } dec_state_t;

endpackage

// File: rtl/delta_acc.sv
// delta_acc: accumulator register with wrap adder and signed-overflow detect.
// Optional feature macro: DELTA_DEC_OVF_EN (overflow detect; tied to 0 when undefined).
// Ports:
//   Clk   in   rising-edge clock
//   Rst   in   synchronous active-low reset, clears the accumulator
//   load  in   acc <= din (keyframe)
//   add   in   acc <= acc + din, wrapping (delta)
//   din   in   keyframe value or delta
//   value out  current accumulator
//   ovf   out  signed overflow of acc + din (combinational)
module delta_acc
    import delta_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 load,
    input  logic                 add,
    input  logic [DATAWIDTH-1:0] din,
    output logic [DATAWIDTH-1:0] value,
    output logic                 ovf
);

    logic [DATAWIDTH-1:0] acc;
    logic [DATAWIDTH-1:0] sum;

    assign sum   = acc + din;
    assign value = acc;

`ifdef DELTA_DEC_OVF_EN
    // Operands share a sign but the result does not.
    assign ovf = (acc[DATAWIDTH-1] == din[DATAWIDTH-1]) &&
                 (sum[DATAWIDTH-1] != acc[DATAWIDTH-1]);
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            acc <= '0;
        end else if (load) begin
            acc <= din;
        end else if (add) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/delta_dec.sv
// delta_dec: streaming delta decoder (integrator), x[n] = x[n-1] + d[n] mod 2^DATAWIDTH.
// Optional feature macro: DELTA_DEC_OVF_EN (drives out_ovf; tied to 0 when undefined).
// Ports:
//   Clk, Rst             rising-edge clock, synchronous active-low reset
//   in_valid/in_ready    input handshake; in_key=1 marks an absolute keyframe
//   in_data              keyframe value or delta
//   out_valid/out_ready  output handshake, one-cycle latency, held under backpressure
//   out_data             reconstructed sample
//   out_key              sample came from a keyframe
//   out_count            deltas applied since last keyframe (saturating)
//   err                  one-cycle pulse: delta received before any keyframe
//   out_ovf              signed overflow on this sample
//
// state    | meaning
// WAIT_KEY | no reference sample yet; deltas are dropped and flagged
// RUN      | accumulator valid; deltas are integrated
module delta_dec
    import delta_pkg::*;
#(
    parameter int DATAWIDTH  = 8,
    parameter int COUNTWIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_key,
    input  logic [DATAWIDTH-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATAWIDTH-1:0]  out_data,
    output logic                  out_key,
    output logic [COUNTWIDTH-1:0] out_count,
    output logic                  err,
    output logic                  out_ovf
);

    localparam logic [COUNTWIDTH-1:0] CNT_MAX = '1;

    dec_state_t state, state_nxt;
    logic       accept;
    logic       load;
    logic       add;
    logic       err_nxt;
    logic       acc_ovf;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= S_WAIT_KEY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        add       = 1'b0;
        err_nxt   = 1'b0;
        if (accept) begin
            if (in_key == FLAG_KEY) begin
                load      = 1'b1;
                state_nxt = S_RUN;
            end else if (state == S_RUN) begin
                add = 1'b1;
            end else begin
                err_nxt = 1'b1;
            end
        end
    end

    // The accumulator always equals the last produced sample, so it doubles
    // as the output data register.
    delta_acc #(
        .DATAWIDTH(DATAWIDTH)
    ) u_acc (
        .Clk  (Clk),
        .Rst  (Rst),
        .load (load),
        .add  (add),
        .din  (in_data),
        .value(out_data),
        .ovf  (acc_ovf)
    );

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            out_valid <= 1'b0;
            out_key   <= 1'b0;
            out_count <= '0;
            err       <= 1'b0;
        end else begin
            err <= err_nxt;
            if (load) begin
                out_valid <= 1'b1;
                out_key   <= 1'b1;
                out_count <= '0;
            end else if (add) begin
                out_valid <= 1'b1;
                out_key   <= 1'b0;
                if (out_count != CNT_MAX) begin
                    out_count <= out_count + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef DELTA_DEC_OVF_EN
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            out_ovf <= 1'b0;
        end else if (load) begin
            out_ovf <= 1'b0;
        end else if (add) begin
            out_ovf <= acc_ovf;
        end
    end
`else
    assign out_ovf = acc_ovf;
`endif

endmodule

// File: tb/tb_delta_dec.sv
// tb_delta_dec: directed self-checking bench for delta_dec (DATAWIDTH=8, COUNTWIDTH=8).
module tb_delta_dec;

    logic       Clk;
    logic       Rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_key;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_key;
    logic [7:0] out_count;
    logic       err;
    logic       out_ovf;

    int n_checks = 0;
    int n_errors = 0;

    delta_dec #(
        .DATAWIDTH (8),
        .COUNTWIDTH(8)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_key   (in_key),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_key  (out_key),
        .out_count(out_count),
        .err      (err),
        .out_ovf  (out_ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic k, input logic [7:0] d);
        in_valid = v;
        in_key   = k;
        in_data  = d;
    endtask

    // Expect a produced sample after the next edge.
    task automatic expect_out(input string tag, input int d, input int k, input int c);
        chk({tag, ".valid"}, out_valid, 1);
        chk({tag, ".data"},  out_data,  d);
        chk({tag, ".key"},   out_key,   k);
        chk({tag, ".count"}, out_count, c);
    endtask

    typedef struct {
        logic       key;
        logic [7:0] data;
        int         exp_d;
        int         exp_c;
    } vec_t;

    vec_t seq1[3] = '{'{1'b1, 8'd10, 10, 0}, '{1'b0, 8'd5, 15, 1}, '{1'b0, 8'hFD, 12, 2}};
    vec_t seq5[5] = '{'{1'b1, 8'd0, 0, 0}, '{1'b0, 8'd1, 1, 1}, '{1'b0, 8'd1, 2, 2},
                      '{1'b1, 8'd100, 100, 0}, '{1'b0, 8'd2, 102, 1}};

    initial begin
        Rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 8'd0);
        tick();
        tick();
        chk("rst.valid", out_valid, 0);
        chk("rst.data",  out_data,  0);
        chk("rst.key",   out_key,   0);
        chk("rst.count", out_count, 0);
        chk("rst.err",   err,       0);
        chk("rst.ovf",   out_ovf,   0);
        Rst = 1'b1;

        // Basic stream
        foreach (seq1[i]) begin
            drive(1'b1, seq1[i].key, seq1[i].data);
            tick();
            expect_out($sformatf("seq1[%0d]", i), seq1[i].exp_d, seq1[i].key ? 1 : 0, seq1[i].exp_c);
            chk("seq1.err", err, 0);
        end
        drive(1'b0, 1'b0, 8'd0);
        tick();
        chk("drain.valid", out_valid, 0);

        // Delta before keyframe
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        drive(1'b1, 1'b0, 8'd4);
        #1;
        chk("nokey.in_ready", in_ready, 1);
        tick();
        chk("nokey.valid", out_valid, 0);
        chk("nokey.err",   err,       1);
        drive(1'b1, 1'b1, 8'd7);
        tick();
        chk("nokey.err_clr", err, 0);
        expect_out("key7", 7, 1, 0);

        // Wrap
        drive(1'b1, 1'b1, 8'd250);
        tick();
        expect_out("wrap.key", 250, 1, 0);
        drive(1'b1, 1'b0, 8'd10);
        tick();
        expect_out("wrap.sum", 4, 0, 1);
        chk("wrap.ovf", out_ovf, 0);
        drive(1'b1, 1'b1, 8'd120);
        tick();
        chk("ovf.key_ovf", out_ovf, 0);
        drive(1'b1, 1'b0, 8'd10);
        tick();
        expect_out("ovf.sum", 130, 0, 1);
`ifdef DELTA_DEC_OVF_EN
        chk("ovf.flag", out_ovf, 1);
`else
        chk("ovf.flag", out_ovf, 0);
`endif
        drive(1'b1, 1'b1, 8'd1);
        tick();
        chk("ovf.clear", out_ovf, 0);

        // Backpressure
        drive(1'b1, 1'b1, 8'd20);
        tick();
        expect_out("bp.key", 20, 1, 0);
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 8'd1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp.in_ready", in_ready, 0);
            tick();
            expect_out("bp.hold", 20, 1, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_ready", in_ready, 1);
        tick();
        expect_out("bp.next", 21, 0, 1);
        drive(1'b0, 1'b0, 8'd0);
        tick();
        chk("bp.drain", out_valid, 0);

        // Keyframe mid-stream
        foreach (seq5[i]) begin
            drive(1'b1, seq5[i].key, seq5[i].data);
            tick();
            expect_out($sformatf("seq5[%0d]", i), seq5[i].exp_d, seq5[i].key ? 1 : 0, seq5[i].exp_c);
        end

        // Count saturation: 260 zero deltas
        drive(1'b1, 1'b1, 8'd3);
        tick();
        drive(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 260; i++) tick();
        expect_out("sat", 3, 0, 255);

        // Reset under backpressure
        drive(1'b1, 1'b1, 8'd5);
        tick();
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 8'd0);
        tick();
        chk("rst2.pre_valid", out_valid, 1);
        Rst = 1'b0;
        tick();
        chk("rst2.valid", out_valid, 0);
        chk("rst2.data",  out_data,  0);
        chk("rst2.key",   out_key,   0);
        chk("rst2.count", out_count, 0);
        chk("rst2.err",   err,       0);
        chk("rst2.ovf",   out_ovf,   0);
        Rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 8'd3);
        tick();
        chk("rst2.delta_err",   err,       1);
        chk("rst2.delta_valid", out_valid, 0);
        drive(1'b0, 1'b0, 8'd0);
        tick();
        chk("rst2.err_pulse", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
